pdm_modulator: RTL

First-order sigma-delta modulator that turns 8-bit unsigned PCM samples into a 1-bit PDM stream. It is the transmit-side counterpart of the PDM moving-sum `filter` (the PDM-to-PCM direction). It takes one sample per programmable period through a valid/ready handshake. For each clock of that period it emits one PDM bit whose ones-density equals sample/256. It drives loopback tests and PDM output pins.

---
 rtl/pdm_pkg.sv | 23 ++
 rtl/pdm_sd_core.sv | 41 ++++
 rtl/pdm_modulator.sv | 113 +++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// ---------------------------------------------------------------------------
// pdm_pkg : shared constants, FSM states and period helper for pdm_modulator
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pdm_pkg;

   localparam int SAMPLE_W_DEF = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // An osr of zero selects the longest period, 256 bits per sample.
   function automatic logic [8:0] period_of(input logic [7:0] osr);
      return (osr == 8'd0) ? 9'd256 : {1'b0, osr};
   endfunction

endpackage

`default_nettype wire

// File: rtl/pdm_sd_core.sv
// ---------------------------------------------------------------------------
// pdm_sd_core : first-order sigma-delta accumulator with registered carry out
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pdm_sd_core #(
   parameter int SAMPLE_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_step,
   input  logic                i_clear,
   input  logic [SAMPLE_W-1:0] i_hold,
   output logic                o_pdm
);

   logic [SAMPLE_W-1:0] r_acc;
   logic                r_pdm;
   logic [SAMPLE_W:0]   w_sum;

   assign w_sum = {1'b0, r_acc} + {1'b0, i_hold};
   assign o_pdm = r_pdm;

   // The carry of the wrap-around sum is the output bit; the residue stays in acc.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_pdm <= 1'b0;
      end else if (i_clear) begin
         r_acc <= '0;
         r_pdm <= 1'b0;
      end else if (i_step) begin
         r_acc <= w_sum[SAMPLE_W-1:0];
         r_pdm <= w_sum[SAMPLE_W];
      end
   end

endmodule

`default_nettype wire

// File: rtl/pdm_modulator.sv
// ---------------------------------------------------------------------------
// pdm_modulator : PCM-to-PDM modulator with valid/ready sample intake
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pdm_modulator
   import pdm_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic [7:0]          osr,
   output logic                pdm,
   output logic                underrun
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [8:0]          r_cnt;
   logic [8:0]          w_cnt_nxt;
   logic [SAMPLE_W-1:0] r_hold;
   logic [SAMPLE_W-1:0] w_hold_nxt;
   logic                r_underrun;
   logic                w_underrun_nxt;
   logic                w_step;
   logic                w_clear;
   logic                w_boundary;
   logic                w_accept;

   assign w_boundary   = (r_state == RUN) && (r_cnt == 9'd1);
   assign sample_ready = en && !rst && ((r_state == IDLE) || w_boundary);
   assign w_accept     = sample_valid && sample_ready;
   assign underrun     = r_underrun;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_hold     <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_hold     <= w_hold_nxt;
         r_underrun <= w_underrun_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_hold_nxt     = r_hold;
      w_underrun_nxt = 1'b0;
      w_step         = 1'b0;
      w_clear        = 1'b0;
      case (r_state)
         IDLE: begin
            w_clear   = 1'b1;
            w_cnt_nxt = '0;
            if (w_accept) begin
               w_hold_nxt  = sample;
               w_cnt_nxt   = period_of(osr);
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (!en) begin
               w_clear     = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end else begin
               w_step = 1'b1;
               if (w_boundary) begin
                  // The last bit of the old sample is produced on this same edge.
                  w_cnt_nxt = period_of(osr);
                  if (sample_valid) begin
                     w_hold_nxt = sample;
                  end else begin
                     w_underrun_nxt = 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt - 9'd1;
               end
            end
         end
         default: begin
            w_clear     = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   pdm_sd_core #(
      .SAMPLE_W (SAMPLE_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .i_step  (w_step),
      .i_clear (w_clear),
      .i_hold  (r_hold),
      .o_pdm   (pdm)
   );

endmodule

`default_nettype wire
